// File: rtl/step_sequencer_pkg.sv
// Shared types and helpers for the step sequencer: condition selects,
// FSM state encoding, step-table entry layout and default sizes.
package step_sequencer_pkg;

  localparam int NSTEP_DEF = 8;
  localparam int DWW_DEF   = 4;
  localparam int STEP_W    = 3;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_A      = 2'b01,
    COND_B      = 2'b10,
    COND_C      = 2'b11
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic [DWW_DEF-1:0] dwell;
    cond_t              cond;
    logic [STEP_W-1:0]  next;
    logic               last;
  } entry_t;

  // Evaluate an entry's gating condition against the live inputs.
  function automatic logic cond_true(input cond_t sel, input logic a,
                                     input logic b, input logic c);
    case (sel)
      COND_ALWAYS: return 1'b1;
      COND_A:      return a;
      COND_B:      return b;
      default:     return c;
    endcase
  endfunction

  // One-hot decode of a step index; bit 0 corresponds to step 0.
  function automatic logic [NSTEP_DEF-1:0] onehot(input logic [STEP_W-1:0] s);
    return NSTEP_DEF'(1) << s;
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control/config/status bundle between the step sequencer and its user.
interface step_sequencer_if #(
  parameter int DWW = 4
) ();
  logic           a;
  logic           b;
  logic           c;
  logic           start;
  logic           halt;
  logic           cfg_we;
  logic [2:0]     cfg_addr;
  logic [DWW-1:0] cfg_dwell;
  logic [1:0]     cfg_cond;
  logic [2:0]     cfg_next;
  logic           cfg_last;
  logic [2:0]     step;
  logic [7:0]     phase;
  logic           busy;
  logic           done;
  logic           c1;
  logic           c2;

  modport master (
    output a, b, c, start, halt, cfg_we, cfg_addr, cfg_dwell, cfg_cond,
           cfg_next, cfg_last,
    input  step, phase, busy, done, c1, c2
  );

  modport slave (
    input  a, b, c, start, halt, cfg_we, cfg_addr, cfg_dwell, cfg_cond,
           cfg_next, cfg_last,
    output step, phase, busy, done, c1, c2
  );
endinterface

// File: rtl/step_sequencer_table.sv
// 8-entry step table: synchronous write (caller gates it to IDLE),
// asynchronous read of the current entry and of the next entry's dwell.
// Reset restores the default chain 0->1->...->7 with step 7 last.
module step_table
  import step_sequencer_pkg::*;
(
  input  logic                ck,
  input  logic                rs,
  input  logic                i_we,
  input  logic [STEP_W-1:0]   i_waddr,
  input  entry_t              i_wentry,
  input  logic [STEP_W-1:0]   i_raddr,
  output entry_t              o_rentry,
  input  logic [STEP_W-1:0]   i_naddr,
  output logic [DWW_DEF-1:0]  o_ndwell
);

  entry_t r_tbl [NSTEP_DEF];

  // Table storage: default chain on reset, single-entry write otherwise.
  always_ff @(posedge ck) begin
    if (!rs) begin
      for (int i = 0; i < NSTEP_DEF; i++) begin
        r_tbl[i] <= '{dwell: '0,
                      cond:  COND_ALWAYS,
                      next:  STEP_W'((i + 1) % NSTEP_DEF),
                      last:  (i == NSTEP_DEF - 1)};
      end
    end else if (i_we) begin
      r_tbl[i_waddr] <= i_wentry;
    end
  end

  assign o_rentry = r_tbl[i_raddr];
  assign o_ndwell = r_tbl[i_naddr].dwell;

endmodule

// File: rtl/step_sequencer.sv
// Programmable step sequencer: walks the step table, holding each step for
// its dwell time and until its gating condition is true, and publishes the
// current step, a one-hot phase vector and the c1/c2 group strobes.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int NSTEP = NSTEP_DEF,
  parameter int DWW   = DWW_DEF
) (
  input  logic             ck,
  input  logic             rs,
  step_sequencer_if.slave  bus
);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [DWW-1:0]      r_cnt;
  logic [NSTEP-1:0]    r_phase;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nx;
  logic [STEP_W-1:0]   w_step_nx;
  logic [DWW-1:0]      w_cnt_nx;
  logic [NSTEP-1:0]    w_phase_nx;
  logic                w_busy_nx;
  logic                w_done_nx;
  logic                w_adv;

  entry_t              w_cur;
  entry_t              w_wentry;
  logic [DWW-1:0]      w_ndwell;
  logic [DWW-1:0]      w_dwell0;
  logic                w_we;
  logic                w_cond;

  assign w_we     = bus.cfg_we && (r_state == ST_IDLE);
  assign w_wentry = '{dwell: bus.cfg_dwell,
                      cond:  cond_t'(bus.cfg_cond),
                      next:  bus.cfg_next,
                      last:  bus.cfg_last};

  step_table u_table (
    .ck       (ck),
    .rs       (rs),
    .i_we     (w_we),
    .i_waddr  (bus.cfg_addr),
    .i_wentry (w_wentry),
    .i_raddr  (r_step),
    .o_rentry (w_cur),
    .i_naddr  (w_cur.next),
    .o_ndwell (w_ndwell)
  );

  assign w_cond = cond_true(w_cur.cond, bus.a, bus.b, bus.c);

  // A write to entry 0 in the start cycle must be seen by the first load,
  // so forward the incoming dwell past the table.
  assign w_dwell0 = (w_we && (bus.cfg_addr == '0)) ? bus.cfg_dwell : w_cur.dwell;

  // Next-state, counter and output decode; halt overrides everything.
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    w_adv      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nx = ST_RUN;
          w_step_nx  = '0;
          w_cnt_nx   = w_dwell0;
        end
      end
      ST_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - DWW'(1);
        end else if (w_cond) begin
          w_adv = 1'b1;
        end else begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cond) begin
          w_adv = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_step_nx  = '0;
        w_cnt_nx   = '0;
      end
    endcase

    if (w_adv) begin
      if (w_cur.last) begin
        w_state_nx = ST_IDLE;
        w_step_nx  = '0;
        w_cnt_nx   = '0;
        w_done_nx  = 1'b1;
      end else begin
        w_state_nx = ST_RUN;
        w_step_nx  = w_cur.next;
        w_cnt_nx   = w_ndwell;
      end
    end

    if (bus.halt) begin
      w_state_nx = ST_IDLE;
      w_step_nx  = '0;
      w_cnt_nx   = '0;
      w_done_nx  = 1'b0;
    end

    w_busy_nx  = (w_state_nx != ST_IDLE);
    w_phase_nx = w_busy_nx ? onehot(w_step_nx) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge ck) begin
    if (!rs) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_cnt   <= w_cnt_nx;
      r_phase <= w_phase_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.step  = r_step;
  assign bus.phase = r_phase;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.c1    = r_phase[1] | r_phase[5] | r_phase[6];
  assign bus.c2    = r_phase[0] | r_phase[2] | r_phase[4];

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: table-driven default-chain walk plus
// hand-written sequences for dwell, condition wait, halt, config lockout
// and mid-run reset.
module tb_step_sequencer;

  logic ck;
  logic rs;
  int   nvec;
  int   nfail;

  step_sequencer_if #(.DWW(4)) bus ();

  step_sequencer u_dut (
    .ck  (ck),
    .rs  (rs),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic       start;
    logic [2:0] step;
    logic [7:0] phase;
    logic       busy;
    logic       done;
    logic       c1;
    logic       c2;
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".step"},  32'(bus.step),  32'd0);
    chk({nm, ".phase"}, 32'(bus.phase), 32'd0);
    chk({nm, ".busy"},  32'(bus.busy),  32'd0);
    chk({nm, ".done"},  32'(bus.done),  32'd0);
    chk({nm, ".c1c2"},  32'({bus.c1, bus.c2}), 32'd0);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [3:0] dwell,
                           input logic [1:0] cond, input logic [2:0] nxt,
                           input logic last);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_dwell = dwell;
    bus.cfg_cond  = cond;
    bus.cfg_next  = nxt;
    bus.cfg_last  = last;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  // Start a run and count edges from the start edge through the done pulse.
  task automatic run_measure(output int n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int exp_dw [6];
    nvec  = 0;
    nfail = 0;

    vt[0] = '{1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 3'd1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 3'd3, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 3'd4, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 3'd5, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 3'd6, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b0, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    rs            = 1'b0;
    bus.a         = 1'b0;
    bus.b         = 1'b0;
    bus.c         = 1'b0;
    bus.start     = 1'b0;
    bus.halt      = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_dwell = '0;
    bus.cfg_cond  = '0;
    bus.cfg_next  = '0;
    bus.cfg_last  = 1'b0;

    // Reset defaults and default-chain walk
    tick();
    tick();
    chk_idle("reset");
    rs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.start = vt[i].start;
      tick();
      chk($sformatf("walk%0d.step", i),  32'(bus.step),  32'(vt[i].step));
      chk($sformatf("walk%0d.phase", i), 32'(bus.phase), 32'(vt[i].phase));
      chk($sformatf("walk%0d.busy", i),  32'(bus.busy),  32'(vt[i].busy));
      chk($sformatf("walk%0d.done", i),  32'(bus.done),  32'(vt[i].done));
      chk($sformatf("walk%0d.c1", i),    32'(bus.c1),    32'(vt[i].c1));
      chk($sformatf("walk%0d.c2", i),    32'(bus.c2),    32'(vt[i].c2));
    end
    bus.start = 1'b0;

    // Dwell: entry 0 held 4 cycles, then step 2 (last) for 1 cycle
    cfg_write(3'd0, 4'd3, 2'b00, 3'd2, 1'b0);
    cfg_write(3'd2, 4'd0, 2'b00, 3'd3, 1'b1);
    exp_dw = '{0, 0, 0, 0, 2, 0};
    bus.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.start = 1'b0;
      chk($sformatf("dwell%0d.step", i), 32'(bus.step), 32'(exp_dw[i]));
      chk($sformatf("dwell%0d.busy", i), 32'(bus.busy), (i < 5) ? 32'd1 : 32'd0);
      chk($sformatf("dwell%0d.done", i), 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
    end
    tick();
    chk("dwell.after.done", 32'(bus.done), 32'd0);

    // Condition wait on input a
    cfg_write(3'd0, 4'd0, 2'b01, 3'd1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("cw.start.step", 32'(bus.step), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("cw.hold%0d.step", i), 32'(bus.step), 32'd0);
      chk($sformatf("cw.hold%0d.busy", i), 32'(bus.busy), 32'd1);
    end
    bus.a = 1'b1;
    tick();
    chk("cw.adv.step",  32'(bus.step),  32'd1);
    chk("cw.adv.phase", 32'(bus.phase), 32'h02);
    bus.a = 1'b0;
    tick();
    chk("cw.step2", 32'(bus.step), 32'd2);
    tick();
    chk("cw.done", 32'(bus.done), 32'd1);

    // Halt mid-run at step 3
    rs = 1'b0;
    tick();
    rs = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("halt.at.step", 32'(bus.step), 32'd3);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk_idle("halt");
    tick();
    chk_idle("halt.next");
    bus.halt  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.halt  = 1'b0;
    bus.start = 1'b0;
    chk("halt.start.busy", 32'(bus.busy), 32'd0);
    run_measure(n);
    chk("halt.replay.len", 32'(n), 32'd9);

    // Config lockout while busy, then accepted in IDLE
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    cfg_write(3'd5, 4'd2, 2'b00, 3'd6, 1'b0);
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    chk("lock.drain.done", 32'(bus.done), 32'd1);
    run_measure(n);
    chk("lock.busy.len", 32'(n), 32'd9);
    cfg_write(3'd5, 4'd2, 2'b00, 3'd6, 1'b0);
    run_measure(n);
    chk("lock.idle.len", 32'(n), 32'd11);

    // Write to entry 0 in the start cycle is used by the first load
    bus.start     = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_dwell = 4'd1;
    bus.cfg_cond  = 2'b00;
    bus.cfg_next  = 3'd1;
    bus.cfg_last  = 1'b0;
    tick();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    chk("startwr.len", 32'(n), 32'd12);

    // Synchronous reset mid-run restores outputs and default table
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.step != 3'd4 && n < 50) begin
      tick();
      n++;
    end
    chk("rst.at.step", 32'(bus.step), 32'd4);
    rs = 1'b0;
    tick();
    rs = 1'b1;
    chk_idle("rst.mid");
    run_measure(n);
    chk("rst.table.len", 32'(n), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
